// File: rtl/mod_phase_pkg.sv
// Shared types and constants for the clock-mod phase sequencer.
// Phase encoding is {SEL2, SEL1}.
package mod_phase_pkg;

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    IDLE      = 2'd1,
    STEP      = 2'd2
  } state_t;

  localparam logic [1:0] PH_0   = 2'b00;
  localparam logic [1:0] PH_90  = 2'b01;
  localparam logic [1:0] PH_180 = 2'b10;
  localparam logic [1:0] PH_270 = 2'b11;

  // One move toward tgt: SEL1 (bit 0) is corrected before SEL2, never both at once.
  function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
    logic [1:0] nxt;
    nxt = cur;
    if (cur[0] != tgt[0]) begin
      nxt[0] = tgt[0];
    end else if (cur[1] != tgt[1]) begin
      nxt[1] = tgt[1];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mod_phase_sequencer_if.sv
// Phase request handshake between a requester (master) and the sequencer (slave).
interface mod_phase_sequencer_if;
  logic [1:0] PHASE_REQ;
  logic       PHASE_REQ_VALID;
  logic       PHASE_REQ_READY;

  modport master (
    output PHASE_REQ,
    output PHASE_REQ_VALID,
    input  PHASE_REQ_READY
  );

  modport slave (
    input  PHASE_REQ,
    input  PHASE_REQ_VALID,
    output PHASE_REQ_READY
  );
endinterface

// File: rtl/lock_sync.sv
// Multi-flop synchronizer for the asynchronous DCM lock status.
// All stages clear to 0 while rst_n is low, so lock is never assumed out of reset.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage_reg [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg[gi] <= 1'b0;
        end else begin
          stage_reg[gi] <= d;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg[gi] <= 1'b0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/mod_phase_sequencer.sv
// Drives the BUFGMUX phase selects one bit at a time with a settle hold per toggle.
// Optional lock-loss counter output enabled by PHASE_SEQ_LOCKLOSS_CNT_EN.
module mod_phase_sequencer
  import mod_phase_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_STABLE   = 64
) (
  input  logic                  USER_CLOCK,
  input  logic                  USER_RST_N,
  input  logic                  DCM_LOCKED,
  mod_phase_sequencer_if.slave  req_if,
  output logic                  CLK_MOD_PHASE_SEL1,
  output logic                  CLK_MOD_PHASE_SEL2,
  output logic [1:0]            PHASE_CUR,
  output logic                  PHASE_DONE,
  output logic                  BUSY
`ifdef PHASE_SEQ_LOCKLOSS_CNT_EN
  ,
  output logic [7:0]            LOCK_LOSS_CNT
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_STABLE + 1);
  // Loading S-1 makes the next decision land exactly S edges after the toggle.
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_STABLE - 1);

  logic          locked_s;
  state_t        state_reg, state_next;
  logic [1:0]    sel_reg, sel_next;
  logic [1:0]    target_reg, target_next;
  logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
  logic [LW-1:0] lock_cnt_reg, lock_cnt_next;
  logic          done_reg, done_next;
  logic          same_pend_reg, same_pend_next;
  logic          ready;
  logic          accept;

  lock_sync #(.STAGES(2)) u_lock_sync (
    .clk   (USER_CLOCK),
    .rst_n (USER_RST_N),
    .d     (DCM_LOCKED),
    .q     (locked_s)
  );

  // A same-phase request finishes from IDLE one edge later, so READY drops for that cycle.
  assign ready  = (state_reg == IDLE) && !same_pend_reg;
  assign accept = ready && req_if.PHASE_REQ_VALID;

  always_ff @(posedge USER_CLOCK or negedge USER_RST_N) begin
    if (!USER_RST_N) begin
      state_reg      <= LOCK_WAIT;
      sel_reg        <= PH_0;
      target_reg     <= PH_0;
      settle_cnt_reg <= '0;
      lock_cnt_reg   <= '0;
      done_reg       <= 1'b0;
      same_pend_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      target_reg     <= target_next;
      settle_cnt_reg <= settle_cnt_next;
      lock_cnt_reg   <= lock_cnt_next;
      done_reg       <= done_next;
      same_pend_reg  <= same_pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    target_next     = target_reg;
    settle_cnt_next = settle_cnt_reg;
    lock_cnt_next   = lock_cnt_reg;
    done_next       = 1'b0;
    same_pend_next  = 1'b0;

    unique case (state_reg)
      LOCK_WAIT: begin
        if (locked_s) begin
          if (lock_cnt_reg == LOCK_LAST) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt_reg + LW'(1);
          end
        end else begin
          lock_cnt_next = '0;
        end
      end

      IDLE: begin
        if (!locked_s) begin
          state_next = LOCK_WAIT;
        end else if (same_pend_reg) begin
          done_next = 1'b1;
        end else if (accept) begin
          target_next = req_if.PHASE_REQ;
          if (req_if.PHASE_REQ == sel_reg) begin
            same_pend_next = 1'b1;
          end else begin
            state_next      = STEP;
            settle_cnt_next = '0;
          end
        end
      end

      STEP: begin
        // Lock loss wins over any pending toggle or completion; selects freeze.
        if (!locked_s) begin
          state_next      = LOCK_WAIT;
          settle_cnt_next = '0;
        end else if (settle_cnt_reg != '0) begin
          settle_cnt_next = settle_cnt_reg - SW'(1);
        end else if (target_reg == sel_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          sel_next        = step_toward(sel_reg, target_reg);
          settle_cnt_next = SETTLE_LOAD;
        end
      end

      default: begin
        state_next = LOCK_WAIT;
      end
    endcase
  end

`ifdef PHASE_SEQ_LOCKLOSS_CNT_EN
  logic [7:0] loss_cnt_reg, loss_cnt_next;

  // Outside LOCK_WAIT the synchronized lock was high last cycle, so a low here is a falling edge.
  always_comb begin
    loss_cnt_next = loss_cnt_reg;
    if ((state_reg != LOCK_WAIT) && !locked_s && (loss_cnt_reg != 8'hFF)) begin
      loss_cnt_next = loss_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge USER_CLOCK or negedge USER_RST_N) begin
    if (!USER_RST_N) begin
      loss_cnt_reg <= 8'd0;
    end else begin
      loss_cnt_reg <= loss_cnt_next;
    end
  end

  assign LOCK_LOSS_CNT = loss_cnt_reg;
`endif

  assign req_if.PHASE_REQ_READY = ready;
  assign CLK_MOD_PHASE_SEL1     = sel_reg[0];
  assign CLK_MOD_PHASE_SEL2     = sel_reg[1];
  assign PHASE_CUR              = sel_reg;
  assign PHASE_DONE             = done_reg;
  assign BUSY                   = (state_reg != IDLE);

endmodule
